video_sink_monitor: RTL

Receive-side counterpart of the VGA timing generator: consumes the pixel-domain video signals (HS, VS, BLANK, RGB) and checks them against the expected geometry. It measures active pixels per line and active lines per frame, flags timing faults in sticky error bits, counts frames and produces a per-frame RGB signature. It sits in simulation benches and optionally in Top, tapped onto the video interface, so frame integrity is checkable without a monitor.

---
 rtl/video_mon_pkg.sv | 27 ++
 rtl/video_edge_sync.sv | 48 ++++
 rtl/video_sink_monitor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/video_mon_pkg.sv
// Shared types and constants for the receive-side video timing monitor.
// Holds the monitor FSM states, the error bit positions and the counter helpers.
package video_mon_pkg;

   typedef enum logic {
      WAIT_VS = 1'b0,
      RUN     = 1'b1
   } mon_state_t;

   localparam int ERR_HLEN = 0;
   localparam int ERR_VLEN = 1;
   localparam int ERR_SYNC = 2;

   localparam int CNT_W = 12;
   localparam int SIG_W = 24;

   // Counters stick at all-ones so an overlong line or frame stays visibly wrong.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] acc,
                                                 input logic [SIG_W-1:0] rgb);
      return {acc[SIG_W-2:0], acc[SIG_W-1]} ^ rgb;
   endfunction

endpackage

// File: rtl/video_edge_sync.sv
// Two-stage input registering of the video signals, with falling-edge
// detection on the frame and line boundaries.
module video_edge_sync
   import video_mon_pkg::*;
(
   input  logic             pixel_clk,
   input  logic             pixel_rst_n,
   input  logic             hs,
   input  logic             vs,
   input  logic             blank,
   input  logic [SIG_W-1:0] rgb,
   output logic             s1_hs,
   output logic             s1_vs,
   output logic             s1_blank,
   output logic [SIG_W-1:0] s1_rgb,
   output logic             vs_fall,
   output logic             blank_fall
);

   logic s2_vs;
   logic s2_blank;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         s1_hs    <= 1'b1;
         s1_vs    <= 1'b1;
         s1_blank <= 1'b0;
         s1_rgb   <= '0;
         s2_vs    <= 1'b1;
         s2_blank <= 1'b0;
      end else begin
         s1_hs    <= hs;
         s1_vs    <= vs;
         s1_blank <= blank;
         s1_rgb   <= rgb;
         s2_vs    <= s1_vs;
         s2_blank <= s1_blank;
      end
   end

   // Idle levels in reset (syncs high, blanking) keep a reset release from
   // looking like a boundary edge.
   assign vs_fall    = s2_vs & ~s1_vs;
   assign blank_fall = s2_blank & ~s1_blank;

endmodule

// File: rtl/video_sink_monitor.sv
// Receive-side video timing monitor: measures line and frame geometry,
// latches sticky timing errors, counts frames and signs each frame's pixels.
module video_sink_monitor
   import video_mon_pkg::*;
#(
   parameter int HDISP = 800,
   parameter int VDISP = 480
) (
   input  logic             pixel_clk,
   input  logic             pixel_rst_n,
   input  logic             video_hs,
   input  logic             video_vs,
   input  logic             video_blank,
   input  logic [SIG_W-1:0] video_rgb,
   input  logic             err_clr,
   output logic             frame_done,
   output logic [15:0]      frame_cnt,
   output logic [CNT_W-1:0] meas_hdisp,
   output logic [CNT_W-1:0] meas_vdisp,
   output logic [SIG_W-1:0] frame_sig,
   output logic [2:0]       err,
   output logic             locked
);

   localparam logic [CNT_W-1:0] HDISP_C = CNT_W'(HDISP);
   localparam logic [CNT_W-1:0] VDISP_C = CNT_W'(VDISP);

   logic             s1_hs;
   logic             s1_vs;
   logic             s1_blank;
   logic [SIG_W-1:0] s1_rgb;
   logic             vs_fall;
   logic             blank_fall;

   mon_state_t       state;
   mon_state_t       state_nxt;

   logic             lock_evt;
   logic             frame_evt;
   logic             line_evt;
   logic             pix_evt;
   logic             sync_evt;

   logic [CNT_W-1:0] px_cnt;
   logic [CNT_W-1:0] line_cnt;
   logic [CNT_W-1:0] line_cnt_closed;
   logic [SIG_W-1:0] acc;
   logic [2:0]       err_set;

   video_edge_sync u_edge_sync (
      .pixel_clk   (pixel_clk),
      .pixel_rst_n (pixel_rst_n),
      .hs          (video_hs),
      .vs          (video_vs),
      .blank       (video_blank),
      .rgb         (video_rgb),
      .s1_hs       (s1_hs),
      .s1_vs       (s1_vs),
      .s1_blank    (s1_blank),
      .s1_rgb      (s1_rgb),
      .vs_fall     (vs_fall),
      .blank_fall  (blank_fall)
   );

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) state <= WAIT_VS;
      else              state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case leaves a latch behind.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_VS: if (vs_fall) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = WAIT_VS;
      endcase
   end

   always_comb begin
      locked    = 1'b0;
      lock_evt  = 1'b0;
      frame_evt = 1'b0;
      line_evt  = 1'b0;
      pix_evt   = 1'b0;
      sync_evt  = 1'b0;
      case (state)
         WAIT_VS: lock_evt = vs_fall;
         RUN: begin
            locked    = 1'b1;
            frame_evt = vs_fall;
            line_evt  = blank_fall;
            pix_evt   = s1_blank;
            sync_evt  = s1_blank & (~s1_vs | ~s1_hs);
         end
         default: ;
      endcase
   end

   // A line that closes on the frame boundary still belongs to the ending frame.
   assign line_cnt_closed = line_evt ? sat_inc(line_cnt) : line_cnt;

   always_comb begin
      err_set           = '0;
      err_set[ERR_HLEN] = line_evt && (px_cnt != HDISP_C);
      err_set[ERR_VLEN] = frame_evt && (line_cnt_closed != VDISP_C);
      err_set[ERR_SYNC] = sync_evt;
   end

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         px_cnt     <= '0;
         line_cnt   <= '0;
         acc        <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         meas_hdisp <= '0;
         meas_vdisp <= '0;
         frame_sig  <= '0;
         err        <= '0;
      end else begin
         frame_done <= 1'b0;

         if (lock_evt || line_evt) px_cnt <= '0;
         else if (pix_evt)         px_cnt <= sat_inc(px_cnt);

         if (line_evt) meas_hdisp <= px_cnt;

         if (lock_evt) begin
            line_cnt <= '0;
            acc      <= '0;
         end else if (frame_evt) begin
            meas_vdisp <= line_cnt_closed;
            frame_sig  <= acc;
            frame_cnt  <= frame_cnt + 16'd1;
            frame_done <= 1'b1;
            line_cnt   <= '0;
            acc        <= '0;
         end else begin
            line_cnt <= line_cnt_closed;
            if (pix_evt) acc <= sig_step(acc, s1_rgb);
         end

         // A new error outranks a clear landing on the same cycle.
         err <= (err & ~{3{err_clr}}) | err_set;
      end
   end

endmodule
